// File: rtl/systemizer_pk_reader_if.sv
// Public-key output stream of systemizer_pk_reader: N-bit words on valid/ready with a last marker.
interface systemizer_pk_reader_if #(
  parameter int unsigned N = 20
);
  logic         pk_valid;
  logic         pk_ready;
  logic [N-1:0] pk_data;
  logic         pk_last;

  modport master (output pk_valid, pk_data, pk_last, input pk_ready);
  modport slave  (input pk_valid, pk_data, pk_last, output pk_ready);
endinterface

// File: rtl/systemizer_pk_reader.sv
// Drains the systemized public-key matrix row-major out of column-block-major block memory.
// Define SYSTEMIZER_PK_READER_FULL_MATRIX_EN to export the identity column blocks as well.
module systemizer_pk_reader #(
  parameter int unsigned N      = 20,
  parameter int unsigned L      = 200,
  parameter int unsigned K      = 400,
  parameter int unsigned RD_LAT = 1,
  localparam int unsigned AW    = $clog2(L * K / N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   fail_in,
  output logic                   busy,
  output logic                   done,
  output logic                   fail,
  output logic                   mem_rd_en,
  output logic [AW-1:0]          mem_rd_addr,
  input  logic [N-1:0]           mem_data_in,
  systemizer_pk_reader_if.master pk
);

  localparam int unsigned NB = K / N;
`ifdef SYSTEMIZER_PK_READER_FULL_MATRIX_EN
  localparam int unsigned CB0 = 0;
`else
  localparam int unsigned CB0 = L / N;
`endif
  localparam int unsigned W    = L * (NB - CB0);
  localparam int unsigned D    = RD_LAT + 2;
  localparam int unsigned AW1  = AW + 1;
  localparam int unsigned CW   = $clog2(NB + 1);
  localparam int unsigned WW   = $clog2(W + 1);
  localparam int unsigned PW   = $clog2(D);
  localparam int unsigned CNTW = $clog2(D + 1);
  localparam int unsigned OW   = $clog2(2 * D + 1);
  localparam logic [AW1-1:0] Base0 = AW1'(CB0 * L);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cb_q;
  logic [AW1-1:0]    acc_q, row_q;
  logic [WW-1:0]     reads_left_q, words_left_q;
  logic              rd_en_q, fail_q;
  logic [AW-1:0]     rd_addr_q;
  logic [RD_LAT-1:0] pipe_q;
  logic [N-1:0]      fifo_q [D];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]   count_q;

  logic          push, pop, issue, start_ok;
  logic [OW-1:0] occ;

  assign start_ok = (state_q == StIdle) && start;
  assign push     = pipe_q[RD_LAT-1];
  assign pop      = pk.pk_valid && pk.pk_ready;

  // Queued words plus reads in flight; a word popped this cycle frees its slot for a new read.
  always_comb begin
    occ = OW'(count_q) + OW'(rd_en_q);
    for (int i = 0; i < RD_LAT; i++) begin
      occ = occ + OW'(pipe_q[i]);
    end
  end

  assign issue = ((state_q == StRun) && (occ < OW'(D) + OW'(pop))) || (start_ok && !fail_in);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = fail_in ? StDone : ((W == 1) ? StDrain : StRun);
      StRun:   if (issue && reads_left_q == WW'(1)) state_d = StDrain;
      StDrain: if (pop && words_left_q == WW'(1)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cb_q         <= CW'(CB0);
      acc_q        <= Base0;
      row_q        <= Base0;
      reads_left_q <= WW'(W);
      words_left_q <= WW'(W);
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      fail_q       <= 1'b0;
      pipe_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      for (int i = 0; i < D; i++) fifo_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rd_en_q <= issue;
      if (start_ok) fail_q <= fail_in;
      // Counters are re-armed on the way back to idle so the first read can issue straight from it.
      if (state_q == StDone) begin
        cb_q         <= CW'(CB0);
        acc_q        <= Base0;
        row_q        <= Base0;
        reads_left_q <= WW'(W);
        words_left_q <= WW'(W);
      end else begin
        if (issue) begin
          rd_addr_q    <= acc_q[AW-1:0];
          reads_left_q <= reads_left_q - WW'(1);
          if (cb_q == CW'(NB - 1)) begin
            cb_q  <= CW'(CB0);
            row_q <= row_q + AW1'(1);
            acc_q <= row_q + AW1'(1);
          end else begin
            cb_q  <= cb_q + CW'(1);
            acc_q <= acc_q + AW1'(L);
          end
        end
        if (pop) words_left_q <= words_left_q - WW'(1);
      end
      pipe_q[0] <= rd_en_q;
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      if (push) begin
        fifo_q[wr_ptr_q] <= mem_data_in;
        wr_ptr_q         <= (wr_ptr_q == PW'(D - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == PW'(D - 1)) ? '0 : rd_ptr_q + PW'(1);
      count_q <= count_q + CNTW'(push) - CNTW'(pop);
    end
  end

  assign busy        = (state_q == StRun) || (state_q == StDrain);
  assign done        = (state_q == StDone);
  assign fail        = fail_q;
  assign mem_rd_en   = rd_en_q;
  assign mem_rd_addr = rd_addr_q;
  assign pk.pk_valid = (count_q != '0);
  assign pk.pk_data  = pk.pk_valid ? fifo_q[rd_ptr_q] : '0;
  assign pk.pk_last  = pk.pk_valid && (words_left_q == WW'(1));

endmodule

// File: tb/tb_systemizer_pk_reader.sv
// Scoreboard bench for systemizer_pk_reader: instance 0 has RD_LAT=1 and pk_ready=1,
// instance 1 has RD_LAT=3 and random pk_ready.
module tb_systemizer_pk_reader;
  localparam int unsigned N  = 4;
  localparam int unsigned L  = 8;
  localparam int unsigned K  = 16;
  localparam int unsigned NB = K / N;
  localparam int unsigned AW = $clog2(L * K / N);
`ifdef SYSTEMIZER_PK_READER_FULL_MATRIX_EN
  localparam int unsigned CB0 = 0;
`else
  localparam int unsigned CB0 = L / N;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    start, fail_in, busy, done, fail, rd_en, pkv, pkl, rdy;
  logic [AW-1:0] rd_addr [2];
  logic [N-1:0]  mdata [2];
  logic [N-1:0]  pkd [2];
  logic          rr, rand_rdy;
  logic [1:0]    bubble_chk;
  int            n_cmp = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  systemizer_pk_reader_if #(.N(N)) if0 ();
  systemizer_pk_reader_if #(.N(N)) if1 ();

  systemizer_pk_reader #(.N(N), .L(L), .K(K), .RD_LAT(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .fail_in(fail_in[0]), .busy(busy[0]),
    .done(done[0]), .fail(fail[0]), .mem_rd_en(rd_en[0]), .mem_rd_addr(rd_addr[0]),
    .mem_data_in(mdata[0]), .pk(if0)
  );
  systemizer_pk_reader #(.N(N), .L(L), .K(K), .RD_LAT(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .fail_in(fail_in[1]), .busy(busy[1]),
    .done(done[1]), .fail(fail[1]), .mem_rd_en(rd_en[1]), .mem_rd_addr(rd_addr[1]),
    .mem_data_in(mdata[1]), .pk(if1)
  );

  assign rdy         = {rr, 1'b1};
  assign if0.pk_ready = rdy[0];
  assign if1.pk_ready = rdy[1];
  assign pkv         = {if1.pk_valid, if0.pk_valid};
  assign pkl         = {if1.pk_last, if0.pk_last};
  assign pkd[0]      = if0.pk_data;
  assign pkd[1]      = if1.pk_data;

  always @(posedge clk) begin
    #2 rr = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_mon
    localparam int Lat = (g == 0) ? 1 : 3;
    logic [AW-1:0] mp [4];
    logic [AW-1:0] qr [$];
    logic [AW-1:0] qd [$];
    logic [AW-1:0] e;
    int            rd_cnt = 0;
    int            v_cnt = 0;
    int            hs = 0;
    int            occ = 0;
    logic          streaming = 1'b0;
    logic          last_hs = 1'b0;
    logic          prev_stall = 1'b0;
    logic [N-1:0]  prev_data;

    // Memory model: each word holds its own address, returned Lat cycles after the read.
    always @(posedge clk) begin
      mp[0] <= rd_addr[g];
      for (int i = 1; i < 4; i++) mp[i] <= mp[i-1];
    end
    assign mdata[g] = N'(mp[Lat-1]);

    always @(negedge clk) begin
      if (rst) begin
        streaming  = 1'b0;
        last_hs    = 1'b0;
        prev_stall = 1'b0;
        occ        = 0;
      end else begin
        if (last_hs) check("done_after_last", done[g], 1'b1);
        if (pkv[g]) v_cnt++;
        if (rd_en[g]) begin
          rd_cnt++;
          occ++;
          check("occupancy_le_d", occ <= Lat + 2, 1'b1);
          check("rd_expected", qr.size() != 0, 1'b1);
          if (qr.size() != 0) check("rd_addr", rd_addr[g], qr.pop_front());
        end
        if (prev_stall) begin
          check("stall_valid", pkv[g], 1'b1);
          check("stall_data", pkd[g], prev_data);
        end
        if (bubble_chk[g] && streaming) check("no_bubble", pkv[g], 1'b1);
        if (pkv[g] && rdy[g]) begin
          hs++;
          occ--;
          check("pk_expected", qd.size() != 0, 1'b1);
          if (qd.size() != 0) begin
            e = qd.pop_front();
            check("pk_data", pkd[g], N'(e));
            check("pk_last", pkl[g], qd.size() == 0);
          end
          streaming = !pkl[g];
        end
        last_hs    = pkv[g] && rdy[g] && pkl[g];
        prev_stall = pkv[g] && !rdy[g];
        prev_data  = pkd[g];
      end
    end
  end

  task automatic fill(input int sel);
    logic [AW-1:0] a;
    for (int r = 0; r < L; r++) begin
      for (int cb = CB0; cb < NB; cb++) begin
        a = AW'(cb * L + r);
        if (sel == 0) begin
          g_mon[0].qr.push_back(a);
          g_mon[0].qd.push_back(a);
        end else begin
          g_mon[1].qr.push_back(a);
          g_mon[1].qd.push_back(a);
        end
      end
    end
  endtask

  function automatic int pending(input int sel);
    if (sel == 0) return g_mon[0].qr.size() + g_mon[0].qd.size();
    return g_mon[1].qr.size() + g_mon[1].qd.size();
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy[0], 0);
    check({tag, "_done"}, done[0], 0);
    check({tag, "_fail"}, fail[0], 0);
    check({tag, "_rd_en"}, rd_en[0], 0);
    check({tag, "_rd_addr"}, rd_addr[0], 0);
    check({tag, "_valid"}, pkv[0], 0);
    check({tag, "_data"}, pkd[0], 0);
    check({tag, "_last"}, pkl[0], 0);
  endtask

  task automatic run(input int sel, input int restart_at);
    int t;
    int lat;
    lat = (sel == 0) ? 1 : 3;
    fill(sel);
    @(negedge clk);
    start[sel]   = 1'b1;
    fail_in[sel] = 1'b0;
    @(negedge clk);
    start[sel] = 1'b0;
    check("first_rd", rd_en[sel], 1'b1);
    check("busy_run", busy[sel], 1'b1);
    check("fail_clear", fail[sel], 1'b0);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      check("valid_latency", pkv[sel], 1'b0);
    end
    @(negedge clk);
    check("valid_first", pkv[sel], 1'b1);
    t = 0;
    while (!done[sel] && t < 400) begin
      start[sel] = (restart_at != 0 && t == restart_at);
      @(negedge clk);
      t++;
    end
    start[sel] = 1'b0;
    check("done_seen", done[sel], 1'b1);
    check("busy_at_done", busy[sel], 1'b0);
    check("fail_low", fail[sel], 1'b0);
    check("scoreboard_empty", pending(sel), 0);
    @(negedge clk);
    check("done_pulse", done[sel], 1'b0);
    check("busy_idle", busy[sel], 1'b0);
  endtask

  initial begin
    int rd0, v0, h0, t;
    rst = 1'b1; start = '0; fail_in = '0; rand_rdy = 1'b0; rr = 1'b1; bubble_chk = 2'b01;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #2 rst = 1'b0;

    run(0, 0);
    run(0, 6);

    // Aborted export: no reads, no words, fail held until the next start.
    rd0 = g_mon[0].rd_cnt;
    v0  = g_mon[0].v_cnt;
    @(negedge clk);
    start[0] = 1'b1; fail_in[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0; fail_in[0] = 1'b0;
    check("abort_done", done[0], 1'b1);
    check("abort_fail", fail[0], 1'b1);
    check("abort_busy", busy[0], 1'b0);
    repeat (5) @(negedge clk);
    check("abort_fail_hold", fail[0], 1'b1);
    check("abort_done_low", done[0], 1'b0);
    check("abort_no_reads", g_mon[0].rd_cnt - rd0, 0);
    check("abort_no_valid", g_mon[0].v_cnt - v0, 0);

    // Reset after five words, then a full replay.
    h0 = g_mon[0].hs;
    fill(0);
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    t = 0;
    while (g_mon[0].hs - h0 < 5 && t < 100) begin
      @(posedge clk);
      t++;
    end
    check("five_words_seen", g_mon[0].hs - h0 >= 5, 1'b1);
    #2 rst = 1'b1;
    #1 check_idle_outputs("midreset");
    g_mon[0].qr.delete();
    g_mon[0].qd.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("post_reset_quiet", {rd_en[0], pkv[0]}, 2'b00);
    end
    run(0, 0);

    rand_rdy = 1'b1;
    run(1, 0);
    rand_rdy = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
